// File: rtl/cmp_sched.sv
// Round-robin arbiter that time-shares one branch comparator between NUM_REQ requesters.
// One request is in flight at a time: IDLE (grant/accept) -> CMP (sample result) -> RESP (hand back).
module cmp_sched #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [32*NUM_REQ-1:0]     req_rs1_d,
  input  logic [32*NUM_REQ-1:0]     req_rs2_d,
  input  logic [3*NUM_REQ-1:0]      req_op,
  output logic [31:0]               cmp_rs1_d,
  output logic [31:0]               cmp_rs2_d,
  output logic [2:0]                cmp_op,
  input  logic                      cmp_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_b,
  output logic                      rsp_err
);

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [ID_W-1:0]   ptr;
  logic              grant_vld;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   cand;
  logic [DATA_W-1:0] sel_rs1;
  logic [DATA_W-1:0] sel_rs2;
  logic [OP_W-1:0]   sel_op;
  logic              accept;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= 3'd5);
  endfunction

  // Sum of two ids is below 2*NUM_REQ, so a single conditional subtract wraps it.
  function automatic logic [ID_W-1:0] wrap_id(input logic [ID_W:0] v);
    logic [ID_W:0] r;
    r = v;
    if (r >= NUM_REQ_W) r = r - NUM_REQ_W;
    return r[ID_W-1:0];
  endfunction

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_id({1'b0, ptr} + (ID_W+1)'(k));
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
    sel_rs1 = req_rs1_d[DATA_W*grant +: DATA_W];
    sel_rs2 = req_rs2_d[DATA_W*grant +: DATA_W];
    sel_op  = req_op[OP_W*grant +: OP_W];
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state == S_IDLE) && grant_vld) req_ready[grant] = 1'b1;
  end

  assign accept = (state == S_IDLE) && grant_vld;

  // Stage boundary: operands registered toward cmp, result captured one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cmp_rs1_d <= '0;
      cmp_rs2_d <= '0;
      cmp_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_b     <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmp_rs1_d <= sel_rs1;
            cmp_rs2_d <= sel_rs2;
            cmp_op    <= sel_op;
            rsp_id    <= grant;
            state     <= S_CMP;
          end
        end
        S_CMP: begin
          rsp_b     <= op_legal(cmp_op) ? cmp_b : 1'b0;
          rsp_err   <= !op_legal(cmp_op);
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= wrap_id({1'b0, rsp_id} + 1'b1);
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sched.sv
// Directed bench for cmp_sched with a behavioural branch comparator attached to the cmp_* port.
module tb_cmp_sched;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_rs1_d;
  logic [32*NUM_REQ-1:0] req_rs2_d;
  logic [3*NUM_REQ-1:0]  req_op;
  logic [31:0]           cmp_rs1_d;
  logic [31:0]           cmp_rs2_d;
  logic [2:0]            cmp_op;
  logic                  cmp_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_b;
  logic                  rsp_err;

  int n_chk = 0;
  int n_err = 0;

  cmp_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1_d(req_rs1_d), .req_rs2_d(req_rs2_d), .req_op(req_op),
    .cmp_rs1_d(cmp_rs1_d), .cmp_rs2_d(cmp_rs2_d), .cmp_op(cmp_op), .cmp_b(cmp_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_b(rsp_b), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External comparator; illegal codes return 1 so the scheduler must mask them.
  always_comb begin
    cmp_b = 1'b1;
    case (cmp_op)
      3'd0: cmp_b = (cmp_rs1_d == cmp_rs2_d);
      3'd1: cmp_b = (cmp_rs1_d != cmp_rs2_d);
      3'd2: cmp_b = ($signed(cmp_rs1_d) <  $signed(cmp_rs2_d));
      3'd3: cmp_b = ($signed(cmp_rs1_d) >= $signed(cmp_rs2_d));
      3'd4: cmp_b = (cmp_rs1_d <  cmp_rs2_d);
      3'd5: cmp_b = (cmp_rs1_d >= cmp_rs2_d);
      default: cmp_b = 1'b1;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
    req_rs1_d[32*id +: 32] = a;
    req_rs2_d[32*id +: 32] = b;
    req_op[3*id +: 3]      = op;
  endtask

  // Full single-requester transaction; called right after a negedge.
  task automatic do_req(input string tag, input int id, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op,
                        input logic exp_b, input logic exp_err);
    logic [NUM_REQ-1:0] exp_rdy;
    exp_rdy     = '0;
    exp_rdy[id] = 1'b1;
    @(negedge clk);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    drive_req(id, a, b, op);
    #1 chk({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(negedge clk);
    req_valid = '0;
    chk({tag, "_ready_cmp"}, 32'(req_ready), 32'd0);
    chk({tag, "_cmp_rs1"}, cmp_rs1_d, a);
    chk({tag, "_cmp_op"}, 32'(cmp_op), 32'(op));
    @(negedge clk);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_b"}, 32'(rsp_b), 32'(exp_b));
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_vld_clr"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int gr[4];
    int rid[4];
    int ng;
    int nr;
    int seen;

    rst = 1'b1;
    req_valid = '0;
    req_rs1_d = '0;
    req_rs2_d = '0;
    req_op    = '0;
    rsp_ready = 1'b0;

    // Reset state, with requests present to check req_ready is gated.
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_cmp_rs1", cmp_rs1_d, 32'd0);
    chk("rst_cmp_op", 32'(cmp_op), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;

    // T1: reset while in CMP
    @(negedge clk);
    req_valid = 2'b01;
    drive_req(0, 32'd10, 32'd10, 3'd0);
    @(negedge clk);
    req_valid = '0;
    chk("t1_in_cmp", cmp_rs1_d, 32'd10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_cmp_rs1", cmp_rs1_d, 32'd0);
    chk("t1_cmp_rs2", cmp_rs2_d, 32'd0);
    chk("t1_vld", 32'(rsp_valid), 32'd0);
    chk("t1_b", 32'(rsp_b), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("t1_no_rsp", 32'(seen), 32'd0);

    // T2, T3, T6
    do_req("t2", 0, 32'd10, 32'd10, 3'd0, 1'b1, 1'b0);
    do_req("t3_slt", 0, 32'hFFFF_FFFC, 32'd3, 3'd2, 1'b1, 1'b0);
    do_req("t3_sltu", 1, 32'hFFFF_FFFC, 32'd3, 3'd4, 1'b0, 1'b0);
    do_req("t3_sgeu", 0, 32'hFFFF_FFFC, 32'd3, 3'd5, 1'b1, 1'b0);
    do_req("t3_sge", 1, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 3'd3, 1'b0, 1'b0);
    do_req("t3_ne", 1, 32'd10, 32'd11, 3'd1, 1'b1, 1'b0);
    do_req("t6_ill", 0, 32'd4, 32'd4, 3'd7, 1'b0, 1'b1);
    do_req("t6_ill6", 1, 32'd4, 32'd4, 3'd6, 1'b0, 1'b1);
    do_req("t6_after", 1, 32'd4, 32'd4, 3'd0, 1'b1, 1'b0);

    // T4: contention from reset, rsp_ready held high
    apply_reset();
    drive_req(0, 32'd1, 32'd2, 3'd2);
    drive_req(1, 32'd5, 32'd5, 3'd1);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    ng = 0;
    nr = 0;
    for (int cyc = 0; cyc < 60 && (ng < 4 || nr < 4); cyc++) begin
      #1;
      if (req_ready != '0) begin
        chk("t4_onehot", 32'($onehot(req_ready)), 32'd1);
        if (ng < 4) gr[ng] = req_ready[1] ? 1 : 0;
        ng++;
      end
      if (rsp_valid) begin
        if (nr < 4) rid[nr] = int'(rsp_id);
        chk("t4_b", 32'(rsp_b), rsp_id == 1'b0 ? 32'd1 : 32'd0);
        nr++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("t4_ngrant", 32'(ng), 32'd4);
    chk("t4_nrsp", 32'(nr), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_grant%0d", k), 32'(gr[k]), 32'(k % 2));
      chk($sformatf("t4_rid%0d", k), 32'(rid[k]), 32'(gr[k]));
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t4_idle", 32'(rsp_valid), 32'd0);

    // T5: backpressure with a competing request waiting
    @(negedge clk);
    drive_req(1, 32'd7, 32'd9, 3'd4);
    drive_req(0, 32'd3, 32'd3, 3'd0);
    req_valid = 2'b10;
    #1 chk("t5_ready1", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    seen = 0;
    repeat (5) begin
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_b !== 1'b1 ||
          rsp_err !== 1'b0 || req_ready !== '0) seen++;
      @(negedge clk);
    end
    chk("t5_stable", 32'(seen), 32'd0);
    chk("t5_held_vld", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t5_vld_clr", 32'(rsp_valid), 32'd0);
    chk("t5_ready0", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = '0;
    chk("t5_cmp_rs1", cmp_rs1_d, 32'd3);
    @(negedge clk);
    chk("t5_id0", 32'(rsp_id), 32'd0);
    chk("t5_b0", 32'(rsp_b), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t5_done", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
